// File: rtl/pre_mant_aligner.sv
// FP32 adder front end: unpacks and orders two operands by magnitude, then right-aligns the
// smaller mantissa to the larger exponent using an iterative shifter, with sticky collection.
module pre_mant_aligner #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [49:0] mant_big,
    output logic [49:0] mant_small,
    output logic        sign_big,
    output logic        sign_small,
    output logic [7:0]  exp_max,
    output logic        sticky,
    output logic        special
);

    typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t      state_reg;
    logic [5:0]  rem_reg;

    logic [31:0] op      [2];
    logic [7:0]  exp_f   [2];
    logic [7:0]  eff_exp [2];
    logic [49:0] mant_u  [2];
    logic        is_inf_nan [2];

    assign op[0] = op_a;
    assign op[1] = op_b;

    // Denormals have no hidden bit and behave as if their exponent were 1.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign exp_f[gi]      = op[gi][30:23];
            assign eff_exp[gi]    = (exp_f[gi] == 8'd0) ? 8'd1 : exp_f[gi];
            assign mant_u[gi]     = {1'b0, (exp_f[gi] != 8'd0), op[gi][22:0], 25'd0};
            assign is_inf_nan[gi] = (exp_f[gi] == 8'hFF);
        end
    endgenerate

    logic        a_big;
    logic [7:0]  eff_big;
    logic [7:0]  eff_small;
    logic [7:0]  diff;
    logic [5:0]  sh;
    logic        is_special;

    // Comparing {exp,frac} as one field orders by magnitude; ties keep op_a as big.
    assign a_big      = (op_a[30:0] >= op_b[30:0]);
    assign eff_big    = a_big ? eff_exp[0] : eff_exp[1];
    assign eff_small  = a_big ? eff_exp[1] : eff_exp[0];
    assign diff       = eff_big - eff_small;
    assign sh         = (diff > 8'd50) ? 6'd50 : diff[5:0];
    assign is_special = is_inf_nan[0] | is_inf_nan[1];

    logic [5:0]  step;
    logic [49:0] lost_mask;

    assign step      = (rem_reg < STEP) ? rem_reg : STEP;
    assign lost_mask = ~({50{1'b1}} << step);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rem_reg    <= 6'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            mant_big   <= 50'd0;
            mant_small <= 50'd0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            exp_max    <= 8'd0;
            sticky     <= 1'b0;
            special    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mant_big   <= a_big ? mant_u[0] : mant_u[1];
                        mant_small <= a_big ? mant_u[1] : mant_u[0];
                        sign_big   <= a_big ? op_a[31] : op_b[31];
                        sign_small <= a_big ? op_b[31] : op_a[31];
                        exp_max    <= a_big ? exp_f[0] : exp_f[1];
                        sticky     <= 1'b0;
                        special    <= is_special;
                        rem_reg    <= is_special ? 6'd0 : sh;
                        in_ready   <= 1'b0;
                        if (is_special || sh == 6'd0) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state_reg <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    mant_small <= mant_small >> step;
                    sticky     <= sticky | (|(mant_small & lost_mask));
                    rem_reg    <= rem_reg - step;
                    if (rem_reg == step) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_mant_aligner.sv
// Scoreboard bench for pre_mant_aligner: directed operand pairs with hand-computed results,
// a negedge monitor pops expectations and checks every cycle the result is presented.
module tb_pre_mant_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [49:0] mant_big;
    logic [49:0] mant_small;
    logic        sign_big;
    logic        sign_small;
    logic [7:0]  exp_max;
    logic        sticky;
    logic        special;

    pre_mant_aligner #(.SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .mant_big(mant_big), .mant_small(mant_small), .sign_big(sign_big),
        .sign_small(sign_small), .exp_max(exp_max), .sticky(sticky), .special(special)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [49:0] mb;
        logic [49:0] ms;
        logic        sgb;
        logic        sgs;
        logic [7:0]  em;
        logic        st;
        logic        sp;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [49:0] ONE = 50'h1000000000000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [49:0] mb, input logic [49:0] ms, input logic sgb,
                                input logic sgs, input logic [7:0] em, input logic st,
                                input logic sp, input int lat);
        exp_t e;
        e.mb = mb; e.ms = ms; e.sgb = sgb; e.sgs = sgs; e.em = em;
        e.st = st; e.sp = sp; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Monitor: pop on first sight of a result, then re-check it every cycle it is held.
    exp_t cur;
    bit   holding = 0;
    bit   check_idle = 0;
    always @(negedge clk) begin
        if (rst) begin
            holding    = 0;
            check_idle = 0;
        end else begin
            if (check_idle) begin
                chk("idle_in_ready", 64'(in_ready), 64'd1);
                chk("idle_out_valid", 64'(out_valid), 64'd0);
                check_idle = 0;
            end
            if (out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
                    end else begin
                        cur     = sb.pop_front();
                        holding = 1;
                        chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                    end
                end
                if (holding) begin
                    $display("result: mant_big=%h mant_small=%h sb=%0d ss=%0d exp_max=%h sticky=%0d special=%0d",
                             mant_big, mant_small, sign_big, sign_small, exp_max, sticky, special);
                    chk("mant_big", 64'(mant_big), 64'(cur.mb));
                    chk("mant_small", 64'(mant_small), 64'(cur.ms));
                    chk("sign_big", 64'(sign_big), 64'(cur.sgb));
                    chk("sign_small", 64'(sign_small), 64'(cur.sgs));
                    chk("exp_max", 64'(exp_max), 64'(cur.em));
                    chk("sticky", 64'(sticky), 64'(cur.st));
                    chk("special", 64'(special), 64'(cur.sp));
                    chk("busy_in_ready", 64'(in_ready), 64'd0);
                end
                if (out_ready) begin
                    holding    = 0;
                    check_idle = 1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int w = 0;
        exp_t x = e;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        x.acc    = cyc;
        sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid || holding) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_mant_big"}, 64'(mant_big), 64'd0);
        chk({tag, "_mant_small"}, 64'(mant_small), 64'd0);
        chk({tag, "_flags"}, 64'({sign_big, sign_small, sticky, special}), 64'd0);
        chk({tag, "_exp_max"}, 64'(exp_max), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // 1: equal operands, no shift
        send(32'h3F800000, 32'h3F800000, mk(ONE, ONE, 0, 0, 8'h7F, 0, 0, 1));
        drain();
        // 2: b larger, d=3
        send(32'h3F800000, 32'h41000000, mk(ONE, 50'h200000000000, 0, 0, 8'h82, 0, 0, 2));
        drain();
        // exactly one full step, d=8
        send(32'h3F800000, 32'h43800000, mk(ONE, 50'h10000000000, 0, 0, 8'h87, 0, 0, 2));
        drain();
        // 3: d=40, small operand negative
        send(32'hBF800000, 32'h53800000, mk(ONE, 50'h100, 0, 1, 8'hA7, 0, 0, 6));
        // in_valid while busy must be ignored
        @(negedge clk);
        op_a = 32'h40000000; op_b = 32'h40400000; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        drain();
        // 4: d=64 clamps to 50, everything lands in sticky
        send(32'h3F800001, 32'h5F800000, mk(ONE, 50'd0, 0, 0, 8'hBF, 1, 0, 8));
        drain();
        // d=30, fraction lsb shifted out -> sticky
        send(32'h3F800001, 32'h4E800000, mk(ONE, 50'h40000, 0, 0, 8'h9D, 1, 0, 5));
        drain();
        // d=3 with fraction lsb kept inside the extension
        send(32'h41000000, 32'h3F800001, mk(ONE, 50'h200000400000, 0, 0, 8'h82, 0, 0, 2));
        drain();
        // magnitude tie with opposite signs: op_a is big
        send(32'h3F800000, 32'hBF800000, mk(ONE, ONE, 0, 1, 8'h7F, 0, 0, 1));
        drain();
        // denormal vs smallest normal: effective exponents equal
        send(32'h00000001, 32'h00800000, mk(ONE, 50'h2000000, 0, 0, 8'h01, 0, 0, 1));
        drain();

        // 5: backpressure for 5 cycles
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, mk(ONE, ONE, 0, 0, 8'h7F, 0, 0, 1));
        begin
            int w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // 6: reset in the middle of ALIGN discards the operation
        send(32'hBF800000, 32'h53800000, mk(ONE, 50'h100, 0, 1, 8'hA7, 0, 0, 6));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check_reset_state("midreset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        // Inf operand: ordered but unshifted, special set
        send(32'h7F800000, 32'h3F800000, mk(ONE, ONE, 0, 0, 8'hFF, 0, 1, 1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
